// File: rtl/clock_div_multi.sv
// Multi-channel programmable clock divider: per-channel tick (clock enable) and
// near-50% square wave, with divisor changes shadowed until a period boundary.
module clock_div_multi #(
  parameter int NUM_CH   = 4,
  parameter int DIV_W    = 16,
  parameter int DIV_INIT = 4,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              sync_i,
  input  logic              cfg_we_i,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic [DIV_W-1:0]  cfg_div_i,
  output logic [NUM_CH-1:0] tick_o,
  output logic [NUM_CH-1:0] clk_o,
  output logic [NUM_CH-1:0] en_o,
  output logic [NUM_CH-1:0] pend_o
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_sh;
    logic [DIV_W-1:0] cnt;
    logic             pend;
    logic             tick;
    logic             div_clk;

    logic             enabled;
    logic             wr;
    logic             wrap;
    logic             apply;
    logic             run_next;
    logic [DIV_W-1:0] div_new;
    logic [DIV_W-1:0] cnt_nxt;
    logic [DIV_W:0]   hi;

    // A disabled channel has no period to finish, so a pending divisor lands at once.
    always_comb begin
      enabled  = (div >= DIV_W'(2));
      wr       = cfg_we_i && (cfg_ch_i == CH_W'(c));
      wrap     = enabled && ((cnt == div - DIV_W'(1)) || sync_i);
      apply    = pend && (wrap || !enabled);
      div_new  = apply ? div_sh : div;
      run_next = (div_new >= DIV_W'(2));
      cnt_nxt  = '0;
      if (run_next && enabled && !wrap)
        cnt_nxt = cnt + DIV_W'(1);
      // Extra bit keeps (D+1) from overflowing at the maximum divisor.
      hi = ({1'b0, div_new} + (DIV_W+1)'(1)) >> 1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        div     <= DIV_W'(DIV_INIT);
        div_sh  <= '0;
        cnt     <= DIV_W'(DIV_INIT - 1);
        pend    <= 1'b0;
        tick    <= 1'b0;
        div_clk <= 1'b0;
      end else begin
        div     <= div_new;
        cnt     <= cnt_nxt;
        tick    <= run_next && (cnt_nxt == '0);
        div_clk <= run_next && ({1'b0, cnt_nxt} < hi);
        // A write on the apply edge refills the shadow and stays pending.
        if (wr) begin
          div_sh <= cfg_div_i;
          pend   <= 1'b1;
        end else if (apply) begin
          pend   <= 1'b0;
        end
      end
    end

    assign tick_o[c] = tick;
    assign clk_o[c]  = div_clk;
    assign en_o[c]   = enabled;
    assign pend_o[c] = pend;
  end

endmodule

// File: tb/tb_clock_div_multi.sv
// Directed bench for clock_div_multi: a behavioural per-channel model predicts
// each edge's outputs into a queue that is checked one microsecond-free step later.
module tb_clock_div_multi;
  localparam int NUM_CH = 4;
  localparam int DIV_W  = 16;
  localparam int CH_W   = 2;

  logic              sys_clk;
  logic              sys_rst_n;
  logic              sync_i;
  logic              cfg_we_i;
  logic [CH_W-1:0]   cfg_ch_i;
  logic [DIV_W-1:0]  cfg_div_i;
  logic [NUM_CH-1:0] tick_o;
  logic [NUM_CH-1:0] clk_o;
  logic [NUM_CH-1:0] en_o;
  logic [NUM_CH-1:0] pend_o;

  clock_div_multi #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .DIV_INIT(4)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .sync_i   (sync_i),
    .cfg_we_i (cfg_we_i),
    .cfg_ch_i (cfg_ch_i),
    .cfg_div_i(cfg_div_i),
    .tick_o   (tick_o),
    .clk_o    (clk_o),
    .en_o     (en_o),
    .pend_o   (pend_o)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] sb[$];

  // Model state: active divisor, shadow, pending flag, phase within period.
  int md[NUM_CH], msh[NUM_CH], mpnd[NUM_CH], mph[NUM_CH];
  logic [NUM_CH-1:0] mt, mk;

  task automatic modelReset();
    for (int c = 0; c < NUM_CH; c++) begin
      md[c] = 4; msh[c] = 0; mpnd[c] = 0; mph[c] = 3;
    end
    mt = '0; mk = '0;
  endtask

  task automatic modelEdge(input logic we, input int ch, input int dv, input logic sy);
    for (int c = 0; c < NUM_CH; c++) begin
      if (md[c] >= 2) begin
        logic w;
        w = (mph[c] == md[c] - 1) || sy;
        if (w && mpnd[c] != 0) begin md[c] = msh[c]; mpnd[c] = 0; end
        if (md[c] < 2) begin
          mph[c] = 0; mt[c] = 0; mk[c] = 0;
        end else begin
          mph[c] = w ? 0 : mph[c] + 1;
          mt[c] = (mph[c] == 0);
          mk[c] = (mph[c] < (md[c] + 1) / 2);
        end
      end else if (mpnd[c] != 0) begin
        md[c] = msh[c]; mpnd[c] = 0; mph[c] = 0;
        mt[c] = (md[c] >= 2); mk[c] = (md[c] >= 2);
      end else begin
        mt[c] = 0; mk[c] = 0;
      end
      if (we && ch == c) begin msh[c] = dv; mpnd[c] = 1; end
    end
  endtask

  function automatic logic [15:0] expVec();
    logic [NUM_CH-1:0] en, pd;
    for (int c = 0; c < NUM_CH; c++) begin
      en[c] = (md[c] >= 2);
      pd[c] = (mpnd[c] != 0);
    end
    return {mt, mk, en, pd};
  endfunction

  task automatic checkOutput(input string tag);
    logic [15:0] exp_v, obs_v;
    obs_v = {tick_o, clk_o, en_o, pend_o};
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL %s scoreboard empty, observed %h required an entry", tag, obs_v);
    end else begin
      exp_v = sb.pop_front();
      assert (obs_v === exp_v) else begin
        miscompares++;
        $error("[TB] FAIL %s t=%0t {tick,clk,en,pend} observed %h required %h",
               tag, $time, obs_v, exp_v);
      end
    end
  endtask

  task automatic applyStimulus(input logic we, input int ch, input int dv, input logic sy,
                               input string tag);
    cfg_we_i  = we;
    cfg_ch_i  = CH_W'(ch);
    cfg_div_i = DIV_W'(dv);
    sync_i    = sy;
    modelEdge(we, ch, dv, sy);
    sb.push_back(expVec());
    @(posedge sys_clk);
    #1;
    checkOutput(tag);
    cfg_we_i = 1'b0;
    sync_i   = 1'b0;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, 1'b0, tag);
  endtask

  initial begin
    sys_rst_n = 1'b1;
    sync_i = 1'b0; cfg_we_i = 1'b0; cfg_ch_i = '0; cfg_div_i = '0;
    #1 sys_rst_n = 1'b0;
    modelReset();
    #2;
    sb.push_back({4'b0000, 4'b0000, 4'b1111, 4'b0000});
    checkOutput("reset");
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    idle(9, "defaults");
    idle(1, "pre_wr1");
    applyStimulus(1'b1, 1, 5, 1'b0, "wr_ch1_d5");
    idle(14, "ch1_d5");

    applyStimulus(1'b1, 2, 0, 1'b0, "wr_ch2_d0");
    idle(5, "ch2_off");
    applyStimulus(1'b1, 2, 3, 1'b0, "wr_ch2_d3");
    idle(7, "ch2_d3");

    applyStimulus(1'b1, 3, 6, 1'b0, "wr_ch3_d6");
    idle(9, "ch3_d6");
    applyStimulus(1'b1, 0, 8, 1'b0, "wr_ch0_d8");
    applyStimulus(1'b0, 0, 0, 1'b1, "sync");
    idle(25, "aligned");

    for (int i = 0; i < 20 && (mph[0] != md[0] - 1); i++) idle(1, "seek_wrap");
    applyStimulus(1'b1, 0, 7, 1'b0, "wr_on_wrap");
    idle(18, "ch0_d7");

    applyStimulus(1'b1, 3, 65535, 1'b0, "wr_ch3_max");
    applyStimulus(1'b0, 0, 0, 1'b1, "sync_max");
    idle(6, "ch3_max");
    applyStimulus(1'b1, 3, 1, 1'b0, "wr_ch3_d1");
    applyStimulus(1'b1, 3, 2, 1'b1, "sync_wr");
    idle(6, "ch3_after");

    for (int i = 0; i < 40; i++)
      applyStimulus(($urandom_range(0, 3) == 0), $urandom_range(0, 3),
                    $urandom_range(0, 9), ($urandom_range(0, 11) == 0), "mixed");

    applyStimulus(1'b1, 1, 9, 1'b0, "wr_before_rst");
    #2 sys_rst_n = 1'b0;
    modelReset();
    #1;
    sb.push_back({4'b0000, 4'b0000, 4'b1111, 4'b0000});
    checkOutput("async_rst");
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    idle(10, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
